// File: rtl/turfio_cout_rx_if.sv
// Recovered-command stream from the COUT receiver.
// Handshake: valid-only stream. cout_valid_o is a one-cycle strobe and there
// is no ready; the consumer must take cout_command_o/cout_is_train_o on every
// cycle cout_valid_o is high. Payload is only meaningful while valid is high.
interface turfio_cout_rx_if;
  logic [31:0] cout_command_o;
  logic        cout_valid_o;
  logic        cout_is_train_o;

  modport master (output cout_command_o, output cout_valid_o, output cout_is_train_o);
  modport slave  (input  cout_command_o, input  cout_valid_o, input  cout_is_train_o);
endinterface

// File: rtl/turfio_cout_rx.sv
// COUT link receiver: aligns the 2-bit-per-clock IDDR stream to 32-bit words
// using the training pattern, then emits one recovered word every 16 clocks.
// Optional feature macro: COUT_RX_ERRCNT_EN enables the saturating training
// mismatch counter on err_count_o; without it err_count_o is constant 0.
module turfio_cout_rx #(
  parameter logic              INV_COUT     = 1'b0,
  parameter logic [31:0]       TRAIN_VALUE  = 32'hA55A6996,
  parameter int unsigned       LOCK_COUNT   = 4,
  parameter int unsigned       UNLOCK_COUNT = 3
) (
  input  logic                 if_clk_x2_i,
  input  logic                 if_rst_n_i,
  input  logic [1:0]           cout_dibit_i,
  input  logic                 train_check_i,
  input  logic                 relock_i,
  turfio_cout_rx_if.master     cout_if,
  output logic                 locked_o,
  output logic                 bit_offset_o,
  output logic [15:0]          err_count_o,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);

  state_t      state_q, state_d;
  // Only bits 33:3 of the conceptual 34-bit shift register are ever read:
  // both windows are taken from the updated register, so the two bits that
  // shift out below bit 3 are never observed and are not stored.
  logic [33:3] sr_q, sr_d;
  logic [3:0]  ph_q, ph_d;
  logic        off_q, off_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  miss_q, miss_d;
  logic [31:0] cmd_q, cmd_d;
  logic        valid_q, valid_d;
  logic        is_train_q, is_train_d;
  logic        locked_q, locked_d;
  logic        bit_off_q, bit_off_d;

  logic [1:0]  dibit;
  logic [31:0] win0, win1, win_sel;
  logic        hit0, hit1, sel_hit, boundary, miss_event;

  // Input polarity fix-up and candidate word windows from the updated register.
  always_comb begin
    dibit    = cout_dibit_i ^ {2{INV_COUT}};
    sr_d     = {dibit[1], dibit[0], sr_q[33:5]};
    win0     = {dibit[1], dibit[0], sr_q[33:4]};
    win1     = {dibit[0], sr_q[33:3]};
    win_sel  = off_q ? win1 : win0;
    hit0     = (win0 == TRAIN_VALUE);
    hit1     = (win1 == TRAIN_VALUE);
    sel_hit  = (win_sel == TRAIN_VALUE);
    boundary = (ph_q == 4'd15);
  end

  // Alignment FSM next state and output/next register values.
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q + 4'd1;
    off_d      = off_q;
    cnt_d      = cnt_q;
    miss_d     = miss_q;
    cmd_d      = cmd_q;
    valid_d    = 1'b0;
    is_train_d = is_train_q;
    bit_off_d  = bit_off_q;
    miss_event = 1'b0;
    if (relock_i) begin
      state_d = ST_HUNT;
      cnt_d   = '0;
      miss_d  = '0;
    end else begin
      unique case (state_q)
        ST_HUNT: begin
          cnt_d  = '0;
          miss_d = '0;
          if (hit0 || hit1) begin
            // offset 0 wins a tie
            off_d = ~hit0;
            ph_d  = '0;
            cnt_d = 4'd1;
            if (LOCK_N == 4'd1) begin
              state_d   = ST_LOCKED;
              bit_off_d = ~hit0;
            end else begin
              state_d = ST_VERIFY;
            end
          end
        end
        ST_VERIFY: begin
          if (boundary) begin
            if (sel_hit) begin
              cnt_d = cnt_q + 4'd1;
              if (cnt_q + 4'd1 == LOCK_N) begin
                state_d   = ST_LOCKED;
                bit_off_d = off_q;
              end
            end else begin
              state_d = ST_HUNT;
              cnt_d   = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (boundary) begin
            miss_event = train_check_i & ~sel_hit;
            if (miss_event && (miss_q + 4'd1 == UNLOCK_N)) begin
              // the word that drops lock is not emitted
              state_d = ST_HUNT;
              miss_d  = '0;
              cnt_d   = '0;
            end else begin
              if (miss_event)         miss_d = miss_q + 4'd1;
              else if (train_check_i) miss_d = '0;
              cmd_d      = win_sel;
              valid_d    = 1'b1;
              is_train_d = sel_hit;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // State and datapath registers.
  always_ff @(posedge if_clk_x2_i or negedge if_rst_n_i) begin
    if (!if_rst_n_i) begin
      state_q    <= ST_HUNT;
      sr_q       <= '0;
      ph_q       <= '0;
      off_q      <= 1'b0;
      cnt_q      <= '0;
      miss_q     <= '0;
      cmd_q      <= '0;
      valid_q    <= 1'b0;
      is_train_q <= 1'b0;
      locked_q   <= 1'b0;
      bit_off_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      ph_q       <= ph_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      miss_q     <= miss_d;
      cmd_q      <= cmd_d;
      valid_q    <= valid_d;
      is_train_q <= is_train_d;
      locked_q   <= locked_d;
      bit_off_q  <= bit_off_d;
    end
  end

`ifdef COUT_RX_ERRCNT_EN
  logic [15:0] err_q;

  // Saturating count of training mismatches seen while locked.
  always_ff @(posedge if_clk_x2_i or negedge if_rst_n_i) begin
    if (!if_rst_n_i) begin
      err_q <= '0;
    end else if (relock_i) begin
      err_q <= '0;
    end else if (miss_event && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_count_o = err_q;
`else
  assign err_count_o = '0;
`endif

  assign cout_if.cout_command_o  = cmd_q;
  assign cout_if.cout_valid_o    = valid_q;
  assign cout_if.cout_is_train_o = is_train_q;
  assign locked_o                = locked_q;
  assign bit_offset_o            = bit_off_q;
  assign dbg_state_o             = state_q;

endmodule
